// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// FETCH_CTRL_MISALIGN_EN adds the HALT state for misaligned redirects.
package fetch_pkg;

  localparam int          ADDR_W       = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0;
  localparam logic [31:0] PC_STEP      = 32'd4;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
`ifdef FETCH_CTRL_MISALIGN_EN
    S_OUT,
    S_HALT
`else
    S_OUT
`endif
  } state_e;

  function automatic logic [ADDR_W-1:0] align_pc(
    input logic [ADDR_W-1:0] a
  );
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter register: redirect load, +4 increment, or hold.
// Load wins over increment when both are requested.
module fetch_pc
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc_en,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_en)
      pc_d = load_val;
    else if (inc_en)
      pc_d = pc_q + PC_STEP;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      pc_q <= RESET_PC;
    else
      pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: one outstanding imem request, stale-response drop.
// FETCH_CTRL_MISALIGN_EN adds io_misalign and a sticky HALT state.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_redir_valid,
  input  logic [31:0] io_redir_target,
  output logic        io_imem_req_valid,
  input  logic        io_imem_req_ready,
  output logic [31:0] io_imem_req_addr,
  input  logic        io_imem_resp_valid,
  input  logic [31:0] io_imem_resp_data,
  output logic        io_inst_valid,
  input  logic        io_inst_ready,
  output logic [31:0] io_inst,
`ifdef FETCH_CTRL_MISALIGN_EN
  output logic [31:0] io_inst_pc,
  output logic        io_misalign
`else
  output logic [31:0] io_inst_pc
`endif
);

  state_e      state_q;
  logic        drop_q;
  logic        inst_valid_q;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic [31:0] pc;
  logic        load_en;
  logic        inc_en;
  logic [31:0] load_val;
  logic        hs;

`ifdef FETCH_CTRL_MISALIGN_EN
  logic misalign_q;
  logic halt_go;

  assign halt_go = io_redir_valid
                 && (io_redir_target[1:0] != 2'b00)
                 && (state_q != S_HALT);
  assign load_val = io_redir_target;
  assign load_en  = io_redir_valid && !halt_go
                 && (state_q != S_HALT);
  assign io_misalign = misalign_q;
`else
  assign load_val = align_pc(io_redir_target);
  assign load_en  = io_redir_valid;
`endif

  assign inc_en = (state_q == S_OUT)
               && io_inst_ready && !io_redir_valid;

  fetch_pc #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clock    (clock),
    .reset    (reset),
    .load_en  (load_en),
    .load_val (load_val),
    .inc_en   (inc_en),
    .pc       (pc)
  );

  assign io_imem_req_valid = (state_q == S_REQ);
  assign io_imem_req_addr  = pc;
  assign hs = io_imem_req_valid && io_imem_req_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_REQ;
      drop_q       <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
`ifdef FETCH_CTRL_MISALIGN_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
`ifdef FETCH_CTRL_MISALIGN_EN
      if (halt_go) begin
        state_q      <= S_HALT;
        misalign_q   <= 1'b1;
        drop_q       <= 1'b0;
        inst_valid_q <= 1'b0;
      end else
`endif
      unique case (state_q)
        S_REQ: begin
          if (hs) begin
            state_q <= S_WAIT;
            drop_q  <= io_redir_valid;
          end
        end
        S_WAIT: begin
          // a redirect alongside the response makes that response stale
          if (io_redir_valid && io_imem_resp_valid) begin
            state_q <= S_REQ;
            drop_q  <= 1'b0;
          end else if (io_redir_valid) begin
            drop_q <= 1'b1;
          end else if (io_imem_resp_valid) begin
            if (drop_q) begin
              drop_q  <= 1'b0;
              state_q <= S_REQ;
            end else begin
              inst_q       <= io_imem_resp_data;
              inst_pc_q    <= pc;
              inst_valid_q <= 1'b1;
              state_q      <= S_OUT;
            end
          end
        end
        S_OUT: begin
          if (io_redir_valid || io_inst_ready) begin
            inst_valid_q <= 1'b0;
            state_q      <= S_REQ;
          end
        end
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end

  assign io_inst_valid = inst_valid_q;
  assign io_inst       = inst_q;
  assign io_inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed vector bench for fetch_ctrl, plus misalign and reset sequences.
// Build with FETCH_CTRL_MISALIGN_EN to exercise the HALT path.
module tb_fetch_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
`ifdef FETCH_CTRL_MISALIGN_EN
  logic        misalign;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  fetch_ctrl dut (
    .clock              (clock),
    .reset              (reset),
    .io_redir_valid     (redir_valid),
    .io_redir_target    (redir_target),
    .io_imem_req_valid  (req_valid),
    .io_imem_req_ready  (req_ready),
    .io_imem_req_addr   (req_addr),
    .io_imem_resp_valid (resp_valid),
    .io_imem_resp_data  (resp_data),
    .io_inst_valid      (inst_valid),
    .io_inst_ready      (inst_ready),
    .io_inst            (inst),
`ifdef FETCH_CTRL_MISALIGN_EN
    .io_inst_pc         (inst_pc),
    .io_misalign        (misalign)
`else
    .io_inst_pc         (inst_pc)
`endif
  );

  typedef struct {
    logic        rv;
    logic [31:0] tgt;
    logic        rdy;
    logic        rsp;
    logic [31:0] dat;
    logic        ir;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_inst;
    logic [31:0] e_ipc;
  } vec_t;

  vec_t vq[$];

  task automatic v(
    input logic rv, input logic [31:0] tgt,
    input logic rdy, input logic rsp,
    input logic [31:0] dat, input logic ir,
    input logic e_req, input logic [31:0] e_addr,
    input logic e_iv, input logic [31:0] e_inst,
    input logic [31:0] e_ipc
  );
    vec_t r;
    r.rv = rv; r.tgt = tgt; r.rdy = rdy;
    r.rsp = rsp; r.dat = dat; r.ir = ir;
    r.e_req = e_req; r.e_addr = e_addr;
    r.e_iv = e_iv; r.e_inst = e_inst;
    r.e_ipc = e_ipc;
    vq.push_back(r);
  endtask

  task automatic chk(
    input string n, input logic [31:0] a, input logic [31:0] e
  );
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic drive(
    input logic rv, input logic [31:0] tgt, input logic rdy,
    input logic rsp, input logic [31:0] dat, input logic ir
  );
    redir_valid  = rv;
    redir_target = tgt;
    req_ready    = rdy;
    resp_valid   = rsp;
    resp_data    = dat;
    inst_ready   = ir;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  localparam logic [31:0] I0 = 32'h0000_0013;
  localparam logic [31:0] I1 = 32'h00A0_0093;
  localparam logic [31:0] I2 = 32'h1111_1111;
  localparam logic [31:0] I3 = 32'h3333_3333;
  localparam logic [31:0] TM = 32'hFFFF_FFFC;

  initial begin
    // r0..r4: basic fetch at 0, then at 4
    v(0,0,1,0,0,0,            1,0,0,0,0);
    v(0,0,0,1,I0,0,           0,0,0,0,0);
    v(0,0,0,0,0,1,            0,0,1,I0,0);
    v(0,0,1,0,0,0,            1,4,0,I0,0);
    v(0,0,0,1,I1,0,           0,4,0,I0,0);
    // r5..r9: decode stall with stray responses
    for (int i = 0; i < 5; i++)
      v(0,0,1,1,32'hBAD,0,    0,4,1,I1,4);
    v(0,0,0,0,0,1,            0,4,1,I1,4);
    v(0,0,0,0,0,0,            1,8,0,I1,4);
    v(0,0,1,0,0,0,            1,8,0,I1,4);
    // r13..r16: redirect in WAIT, late stale response
    v(1,32'h100,0,0,0,0,      0,8,0,I1,4);
    v(0,0,0,0,0,0,            0,32'h100,0,I1,4);
    v(0,0,0,1,32'hDEAD,0,     0,32'h100,0,I1,4);
    v(0,0,1,0,0,0,            1,32'h100,0,I1,4);
    // r17..r22: redirect with response, with inst_ready, with hs
    v(1,32'h200,0,1,32'hBEEF,0, 0,32'h100,0,I1,4);
    v(0,0,1,0,0,0,            1,32'h200,0,I1,4);
    v(0,0,0,1,I2,0,           0,32'h200,0,I1,4);
    v(1,32'h300,0,0,0,1,      0,32'h200,1,I2,32'h200);
    v(1,32'h400,1,0,0,0,      1,32'h300,0,I2,32'h200);
    v(0,0,0,1,32'h2222,0,     0,32'h400,0,I2,32'h200);
    // r23..r26: wrap from FFFFFFFC
    v(1,TM,0,0,0,0,           1,32'h400,0,I2,32'h200);
    v(0,0,1,0,0,0,            1,TM,0,I2,32'h200);
    v(0,0,0,1,I3,0,           0,TM,0,I2,32'h200);
    v(0,0,0,0,0,1,            0,TM,1,I3,TM);

    reset = 1'b1;
    drive(0,0,0,0,0,0);
    step();
    step();
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_req_valid", {31'b0, req_valid}, 32'd1);
    chk("rst_req_addr", req_addr, 32'd0);
`ifdef FETCH_CTRL_MISALIGN_EN
    chk("rst_misalign", {31'b0, misalign}, 32'd0);
`endif
    reset = 1'b0;

    foreach (vq[k]) begin
      chk($sformatf("r%0d_req_valid", k), {31'b0, req_valid},
          {31'b0, vq[k].e_req});
      chk($sformatf("r%0d_req_addr", k), req_addr, vq[k].e_addr);
      chk($sformatf("r%0d_inst_valid", k), {31'b0, inst_valid},
          {31'b0, vq[k].e_iv});
      chk($sformatf("r%0d_inst", k), inst, vq[k].e_inst);
      chk($sformatf("r%0d_inst_pc", k), inst_pc, vq[k].e_ipc);
      drive(vq[k].rv, vq[k].tgt, vq[k].rdy,
            vq[k].rsp, vq[k].dat, vq[k].ir);
      step();
    end

    drive(0,0,0,0,0,0);
    chk("wrap_req_valid", {31'b0, req_valid}, 32'd1);
    chk("wrap_req_addr", req_addr, 32'd0);
    chk("wrap_inst_valid", {31'b0, inst_valid}, 32'd0);

    // misaligned redirect
    drive(1,32'h102,0,0,0,0);
    step();
    drive(0,0,0,0,0,0);
`ifdef FETCH_CTRL_MISALIGN_EN
    chk("mis_flag", {31'b0, misalign}, 32'd1);
    chk("mis_req_valid", {31'b0, req_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1,32'h200,1,1,32'h55,1);
      step();
      chk($sformatf("halt%0d_req_valid", i), {31'b0, req_valid}, 32'd0);
      chk($sformatf("halt%0d_inst_valid", i), {31'b0, inst_valid}, 32'd0);
      chk($sformatf("halt%0d_misalign", i), {31'b0, misalign}, 32'd1);
    end
    drive(0,0,0,0,0,0);
`else
    chk("mis_req_valid", {31'b0, req_valid}, 32'd1);
    chk("mis_req_addr", req_addr, 32'h100);
`endif

    // reset asserted while a fetch is outstanding
    drive(0,0,1,0,0,0);
`ifdef FETCH_CTRL_MISALIGN_EN
    reset = 1'b1;
    #1;
    reset = 1'b0;
    step();
`else
    step();
`endif
    chk("mf_wait_req_valid", {31'b0, req_valid}, 32'd0);
    reset = 1'b1;
    #1;
    chk("mf_rst_req_valid", {31'b0, req_valid}, 32'd1);
    chk("mf_rst_req_addr", req_addr, 32'd0);
    chk("mf_rst_inst_valid", {31'b0, inst_valid}, 32'd0);
`ifdef FETCH_CTRL_MISALIGN_EN
    chk("mf_rst_misalign", {31'b0, misalign}, 32'd0);
`endif
    step();
    reset = 1'b0;
    drive(0,0,0,1,32'h77,0);
    step();
    chk("late_req_valid", {31'b0, req_valid}, 32'd1);
    chk("late_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("late_inst", inst, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
